// File: rtl/bicubic_tap_feeder.sv
// Bicubic 4-tap feeder: slides a 4-pixel edge-replicated window over one source row and emits 4 phase beats per column.
// Optional `BICUBIC_FEED_PREFETCH_EN adds a 1-entry pixel prefetch register so each column takes 4 cycles instead of 5.
module bicubic_tap_feeder #(
  parameter int          ROW_W = 960,
  parameter logic [15:0] PH0_W = 16'h0700,
  parameter logic [15:0] PH1_W = 16'hA759,
  parameter logic [15:0] PH2_W = 16'hB649,
  parameter logic [15:0] PH3_W = 16'h957A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [8:0]  pixel_1,
  output logic [8:0]  pixel_2,
  output logic [8:0]  pixel_3,
  output logic [8:0]  pixel_4,
  output logic [3:0]  weight_1,
  output logic [3:0]  weight_2,
  output logic [3:0]  weight_3,
  output logic [3:0]  weight_4,
  output logic [1:0]  m_phase,
  output logic [11:0] m_col,
  output logic        m_last
);

  localparam logic [11:0] ROW_W_L  = ROW_W[11:0];
  localparam logic [11:0] LAST_COL = 12'(ROW_W - 1);

  typedef enum logic [2:0] {IDLE, FILL, EMIT, LOAD, PAD} state_t;

  state_t      state;
  logic [7:0]  tap1, tap2, tap3, tap4;
  logic [11:0] in_cnt;
  logic [11:0] col;
  logic [1:0]  phase;
  logic [15:0] w_q;
  logic        s_fire, beat;
`ifdef BICUBIC_FEED_PREFETCH_EN
  logic        pf_valid;
  logic [7:0]  pf_data;
`endif

  function automatic logic [15:0] ph_w(input logic [1:0] ph);
    case (ph)
      2'd0:    ph_w = PH0_W;
      2'd1:    ph_w = PH1_W;
      2'd2:    ph_w = PH2_W;
      default: ph_w = PH3_W;
    endcase
  endfunction

  assign s_fire = s_valid & s_ready;
  assign beat   = m_valid & m_ready;

  assign pixel_1  = {1'b0, tap1};
  assign pixel_2  = {1'b0, tap2};
  assign pixel_3  = {1'b0, tap3};
  assign pixel_4  = {1'b0, tap4};
  assign weight_1 = w_q[15:12];
  assign weight_2 = w_q[11:8];
  assign weight_3 = w_q[7:4];
  assign weight_4 = w_q[3:0];
  assign m_phase  = phase;
  assign m_col    = col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      tap1    <= '0;
      tap2    <= '0;
      tap3    <= '0;
      tap4    <= '0;
      in_cnt  <= '0;
      col     <= '0;
      phase   <= '0;
      w_q     <= '0;
`ifdef BICUBIC_FEED_PREFETCH_EN
      pf_valid <= 1'b0;
      pf_data  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          if (s_fire) begin
            tap1   <= s_data;
            tap2   <= s_data;
            tap3   <= s_data;
            tap4   <= s_data;
            in_cnt <= 12'd1;
            state  <= FILL;
          end
        end

        FILL: begin
          if (s_fire) begin
            tap1   <= tap2;
            tap2   <= tap3;
            tap3   <= tap4;
            tap4   <= s_data;
            in_cnt <= in_cnt + 12'd1;
            if (in_cnt == 12'd2) begin
              state   <= EMIT;
              col     <= '0;
              phase   <= '0;
              w_q     <= PH0_W;
              m_valid <= 1'b1;
`ifdef BICUBIC_FEED_PREFETCH_EN
              s_ready <= (ROW_W_L > 12'd3);
`else
              s_ready <= 1'b0;
`endif
            end
          end
        end

        LOAD: begin
          if (s_fire) begin
            tap1    <= tap2;
            tap2    <= tap3;
            tap3    <= tap4;
            tap4    <= s_data;
            in_cnt  <= in_cnt + 12'd1;
            col     <= col + 12'd1;
            phase   <= '0;
            w_q     <= PH0_W;
            m_valid <= 1'b1;
            state   <= EMIT;
`ifdef BICUBIC_FEED_PREFETCH_EN
            s_ready <= ((in_cnt + 12'd1) < ROW_W_L);
`else
            s_ready <= 1'b0;
`endif
          end
        end

        PAD: begin
          // right-edge replication: the last real pixel is shifted in again
          tap1    <= tap2;
          tap2    <= tap3;
          tap3    <= tap4;
          col     <= col + 12'd1;
          phase   <= '0;
          w_q     <= PH0_W;
          m_valid <= 1'b1;
          s_ready <= 1'b0;
          state   <= EMIT;
        end

        EMIT: begin
`ifdef BICUBIC_FEED_PREFETCH_EN
          if (s_fire && !(beat && phase == 2'd3)) begin
            pf_valid <= 1'b1;
            pf_data  <= s_data;
            in_cnt   <= in_cnt + 12'd1;
            s_ready  <= 1'b0;
          end
`endif
          if (beat) begin
            if (phase == 2'd3) begin
              m_last <= 1'b0;
              if (col == LAST_COL) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                s_ready <= 1'b1;
                in_cnt  <= '0;
                col     <= '0;
                phase   <= '0;
                w_q     <= '0;
              end else begin
`ifdef BICUBIC_FEED_PREFETCH_EN
                // held, just-arriving or replicated pixel goes straight into tap 4; LOAD only when starved
                if (pf_valid || s_fire || in_cnt >= ROW_W_L) begin
                  tap1  <= tap2;
                  tap2  <= tap3;
                  tap3  <= tap4;
                  col   <= col + 12'd1;
                  phase <= '0;
                  w_q   <= PH0_W;
                  if (pf_valid) begin
                    tap4     <= pf_data;
                    pf_valid <= 1'b0;
                    s_ready  <= (in_cnt < ROW_W_L);
                  end else if (s_fire) begin
                    tap4    <= s_data;
                    in_cnt  <= in_cnt + 12'd1;
                    s_ready <= ((in_cnt + 12'd1) < ROW_W_L);
                  end else begin
                    s_ready <= 1'b0;
                  end
                end else begin
                  state   <= LOAD;
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
                end
`else
                m_valid <= 1'b0;
                if (in_cnt < ROW_W_L) begin
                  state   <= LOAD;
                  s_ready <= 1'b1;
                end else begin
                  state   <= PAD;
                  s_ready <= 1'b0;
                end
`endif
              end
            end else begin
              phase  <= 2'(phase + 2'd1);
              w_q    <= ph_w(2'(phase + 2'd1));
              m_last <= (phase == 2'd2) && (col == LAST_COL);
            end
          end
        end

        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_tap_feeder.sv
// Directed scoreboard bench for bicubic_tap_feeder (ROW_W=4): windows, phases, weights, stalls, reset, throughput.
module tb_bicubic_tap_feeder;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [7:0]  s_data;
  logic [8:0]  pixel_1, pixel_2, pixel_3, pixel_4;
  logic [3:0]  weight_1, weight_2, weight_3, weight_4;
  logic [1:0]  m_phase;
  logic [11:0] m_col;

  bicubic_tap_feeder #(.ROW_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .pixel_1(pixel_1), .pixel_2(pixel_2), .pixel_3(pixel_3), .pixel_4(pixel_4),
    .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3), .weight_4(weight_4),
    .m_phase(m_phase), .m_col(m_col), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  t1, t2, t3, t4;
    logic [1:0]  ph;
    logic [11:0] col;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] row[W];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         span;

  function automatic logic [15:0] exp_w(input logic [1:0] ph);
    case (ph)
      2'd0:    exp_w = 16'h0700;
      2'd1:    exp_w = 16'hA759;
      2'd2:    exp_w = 16'hB649;
      default: exp_w = 16'h957A;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_row();
    beat_t b;
    for (int c = 0; c < W; c++) begin
      for (int k = 0; k < 4; k++) begin
        b.t1   = row[(c > 0) ? c - 1 : 0];
        b.t2   = row[c];
        b.t3   = row[(c + 1 < W) ? c + 1 : W - 1];
        b.t4   = row[(c + 2 < W) ? c + 2 : W - 1];
        b.ph   = 2'(k);
        b.col  = 12'(c);
        b.last = (c == W - 1) && (k == 3);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {s_ready, m_valid, m_last, pixel_1, pixel_2, pixel_3, pixel_4,
              weight_1, weight_2, weight_3, weight_4, m_phase, m_col}, 64'd0);
  endtask

  // Drives one row and scores beats; stall_beat/rst_beat count from 1, 0 disables.
  task automatic run_row(input int stall_beat, input int stall_len, input int rst_beat,
                         input bit hold255, output int span_o);
    int    src_idx = 0, beats = 0, stall_left = 0, budget = 400;
    int    first = -1, lastc = -1, third = -1;
    bit    stall_done = 0, did_rst = 0;
    beat_t obs;
    span_o = -1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      cyc++;
      budget--;
      if (stall_beat > 0 && !stall_done && m_valid && beats == stall_beat - 1) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'b1;
      end
      s_valid = (src_idx < W) || (hold255 && m_valid);
      s_data  = (hold255 && m_valid) || src_idx >= W ? 8'd255 : row[src_idx];
      if (hold255 && m_valid) chk("no_accept_in_emit", 64'(s_ready), 64'd0);
      if (s_valid && s_ready) begin
        if (src_idx < W && !(hold255 && m_valid)) begin
          src_idx++;
          if (src_idx == 3) third = cyc;
        end
      end
      if (m_valid) begin
        if (rst_beat > 0 && beats == rst_beat - 1) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("reset_mid_row");
          exp_q.delete();
          did_rst = 1;
        end else begin
          obs = '{t1: pixel_1[7:0], t2: pixel_2[7:0], t3: pixel_3[7:0], t4: pixel_4[7:0],
                  ph: m_phase, col: m_col, last: m_last};
          chk("beat", 64'(obs), 64'(exp_q[0]));
          chk("weights", 64'({weight_1, weight_2, weight_3, weight_4}), 64'(exp_w(exp_q[0].ph)));
          chk("sign_bits", 64'({pixel_1[8], pixel_2[8], pixel_3[8], pixel_4[8]}), 64'd0);
          if (m_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (first < 0) begin
              first = cyc;
              chk("first_beat_latency", 64'(first - third), 64'd1);
            end
            lastc = cyc;
          end
        end
      end
    end
    if (budget == 0) chk("row_timeout", 64'(exp_q.size()), 64'd0);
    if (!did_rst) begin
      chk("pixels_consumed", 64'(src_idx), 64'(W));
      span_o = lastc - first + 1;
      @(negedge clk);
      cyc++;
      s_valid = 1'b0;
      m_ready = 1'b1;
      chk("idle_after_row", 64'({m_valid, s_ready, m_last}), 64'b010);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Row 10,20,30,40 with free-flowing consumer
    row = '{8'd10, 8'd20, 8'd30, 8'd40};
    push_row();
    run_row(0, 0, 0, 1'b0, span);
`ifdef BICUBIC_FEED_PREFETCH_EN
    chk("row_span_cycles", 64'(span), 64'd16);
`else
    chk("row_span_cycles", 64'(span), 64'd19);
`endif

    // Same row, consumer stalls 3 cycles at beat 5
    push_row();
    run_row(5, 3, 0, 1'b0, span);

`ifndef BICUBIC_FEED_PREFETCH_EN
    // s_valid held high with 255 while beats are being emitted
    row = '{8'd7, 8'd0, 8'd200, 8'd99};
    push_row();
    run_row(0, 0, 0, 1'b1, span);
`endif

    // Reset during beat 6, then a fresh row
    row = '{8'd50, 8'd60, 8'd70, 8'd80};
    push_row();
    run_row(0, 0, 6, 1'b0, span);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    row = '{8'd1, 8'd2, 8'd3, 8'd4};
    push_row();
    run_row(0, 0, 0, 1'b0, span);

    // Boundary pixel values
    row = '{8'd255, 8'd0, 8'd255, 8'd128};
    push_row();
    run_row(2, 1, 0, 1'b0, span);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
